seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the 8-digit, active-low 7-segment display between two requesters.
- Requester 0 is the live resolution/status banner and is the default owner.
- Requester 1 is an event message source. It takes the display for a fixed hold time and then hands it back.
- Owns digit scanning (divider, digit index, anti-ghost blanking) and switches owner only on frame boundaries, so no frame is ever torn between sources.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 100: cycles at the start of each digit slot during which all anodes are off.
- HOLD_FRAMES, 250: full 8-digit frames that requester 1 owns the display per grant (2 s at defaults). Must be ≥ 1.

Ports:
- clock, input, 1: system clock.
- sys_rst_n, input, 1: reset, asynchronous assert, active-low.
- src0_data, input, 64: requester 0 pattern. Digit d uses bits [63-8d : 56-8d]; active-low segments {dp,g..a}.
- src1_valid, input, 1: requester 1 request. Level is held until ack.
- src1_data, input, 64: requester 1 pattern, same layout. Stable while src1_valid=1.
- src1_ack, output, 1: one-cycle pulse when src1_data is latched.
- control, output, 8: anode enables, active-low. Digit 0 = 8'b01111111 … digit 7 = 8'b11111110.
- cube_data, output, 8: segment drive, active-low.
- owner, output, 1: 0 = requester 0 on display, 1 = requester 1 on display.
- busy, output, 1: 1 in PEND1 or SHOW1.

Behaviour:
- Reset (sys_rst_n=0, async):
  - control=8'hFF, cube_data=8'hFF, owner=0, busy=0, src1_ack=0.
  - Scan counter=0, digit=0, hold counter=0, state=SHOW0, latch buffer=all 1s.
  - Reset mid-grant discards the latched message with no ack.
- Scan timing:
  - Cycle counter runs 0..SCAN_DIV-1 and wraps. Digit index advances on wrap and goes 7→0.
  - frame_start is the cycle where the counter=0 and digit=0.
- Outputs are registered, one cycle behind the counter.
  - Counter < BLANK_CYCLES: control=8'hFF and cube_data=8'hFF.
  - Otherwise: control = one-hot-low for the current digit, and cube_data = that digit's byte from the active source.
- Active source:
  - SHOW0 and PEND1: src0_data, sampled live every digit slot with no shadowing.
  - SHOW1: latch buffer.
- State machine:
  - SHOW0: on src1_valid=1, latch src1_data, pulse src1_ack next cycle, go to PEND1.
  - PEND1: wait for frame_start. On frame_start go to SHOW1, set owner=1, and load hold counter=HOLD_FRAMES.
  - SHOW1: on each frame_start, decrement hold. When hold==1 at frame_start, go to SHOW0 with owner=0 on that same boundary.
  - SHOW1 re-request: src1_valid=1 re-latches data, pulses ack, reloads hold=HOLD_FRAMES at the next frame_start, and stays in SHOW1. Display content changes only at frame_start; the new latch goes into a pending slot until then.
  - PEND1 re-request: overwrites the latch and acks again.
- Simultaneous events:
  - src1_valid arriving in the same cycle as the SHOW1→SHOW0 expiry: expiry wins, then the request is accepted in SHOW0 next cycle, with ack one cycle later.
  - frame_start in the same cycle as the PEND1 latch: the transition waits for the next frame_start.
- src1_ack is never asserted in two consecutive cycles. The requester must drop src1_valid the cycle after ack; otherwise the request is re-accepted.
- Widths:
  - Scan counter: $clog2(SCAN_DIV) bits.
  - Hold counter: $clog2(HOLD_FRAMES+1) bits.
  - No arithmetic overflow is possible; wrap is explicit compare-and-clear.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS=8, SEG_BLANK=8'hFF, ANODE_OFF=8'hFF.
  - Anode lookup function digit→one-hot-low.
  - State typedef {SHOW0, PEND1, SHOW1}.
- One sub-module, seg_scan_timer, contains:
  - Inputs clock and sys_rst_n.
  - Outputs digit[2:0], blank, frame_start.
  - Parameters SCAN_DIV and BLANK_CYCLES.
- The arbiter FSM, latch and output mux stay in the top.

Test Plan:
All tests use SCAN_DIV=10, BLANK_CYCLES=2, HOLD_FRAMES=3.
1. Reset, then idle with src0_data=64'h82_99_C0_FF_FF_99_80_C0.
   - Counter 0–1 of each slot: control=FF, cube_data=FF.
   - Counter 2–9: digit 0 shows control=7F, cube_data=82; digit 7 shows control=FE, cube_data=C0.
   - Frame period = 80 cycles. owner=0.
2. Pulse src1_valid mid-frame with src1_data=64'h00…00.
   - src1_ack is one cycle later. busy=1 immediately.
   - owner=1 and cube_data=00 (non-blank) from the next frame_start, for exactly 3 frames = 240 cycles.
   - Then owner=0, busy=0, and src0 data returns.
3. Re-request during SHOW1 frame 2 with 64'hFE…FE.
   - Ack pulses. Display switches to FE at the next frame_start.
   - Hold reloads: total SHOW1 time = 1 + 1 + 3 frames.
4. Drive src1_valid at the exact expiry frame_start cycle.
   - owner falls to 0 at that boundary. Ack comes 2 cycles after the boundary.
   - owner returns to 1 at the following frame_start.
5. Assert sys_rst_n=0 asynchronously in SHOW1, mid-slot.
   - control and cube_data are FF in the same cycle, with no clock edge required.
   - After release: owner=0, digit=0, src0 is displayed, no ack.
6. Over 10 frames, sample control.
   - control is never zero-hot and never multi-hot.
   - Every digit change is preceded by exactly 2 blank cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit display arbiter: constants, FSM states,
// and digit/anode lookup helpers.
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        PEND1 = 2'd1,
        SHOW1 = 2'd2
    } arb_state_t;

    // Digit 0 drives the MSB anode low, digit 7 the LSB.
    function automatic logic [7:0] anode_sel(input logic [2:0] digit);
        return ~(8'h80 >> digit);
    endfunction

    // Digit 0 lives in the top byte of the 64-bit pattern.
    function automatic logic [7:0] digit_byte(input logic [63:0] pattern,
                                              input logic [2:0]  digit);
        return pattern[63 - 8 * int'(digit) -: 8];
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side bus of the display arbiter: live banner pattern plus the
// event-message request/ack handshake.
interface seg_display_arbiter_if;

    logic [63:0] src0_data;
    logic        src1_valid;
    logic [63:0] src1_data;
    logic        src1_ack;

    modport master (
        output src0_data,
        output src1_valid,
        output src1_data,
        input  src1_ack
    );

    modport slave (
        input  src0_data,
        input  src1_valid,
        input  src1_data,
        output src1_ack
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Digit-slot timebase: slot counter, digit index, anti-ghost blanking window
// and the frame boundary strobe.
module seg_scan_timer #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clock,
    input  logic       sys_rst_n,
    output logic [2:0] digit,
    output logic       blank,
    output logic       frame_start
);

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt   <= '0;
            digit <= 3'd0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 3'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign blank       = (cnt < CNT_BLANK);
    assign frame_start = (cnt == '0) && (digit == 3'd0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-source 7-segment display arbiter: banner by default, event messages
// take over for a fixed number of whole frames, ownership moves on frame edges.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 100,
    parameter int HOLD_FRAMES  = 250
) (
    input  logic                  clock,
    input  logic                  sys_rst_n,
    seg_display_arbiter_if.slave  req,
    output logic [7:0]            control,
    output logic [7:0]            cube_data,
    output logic                  owner,
    output logic                  busy
);

    localparam int               HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

    logic [2:0]        digit;
    logic              blank;
    logic              frame_start;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [63:0]       latch_buf;
    logic [63:0]       disp_buf;
    logic              pend_new;
    logic [HOLD_W-1:0] hold;
    logic              ack_q;

    logic              accept;
    logic              expire;
    logic              load_disp;
    logic [7:0]        src_byte;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clock       (clock),
        .sys_rst_n   (sys_rst_n),
        .digit       (digit),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always_ff @(posedge clock or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= SHOW0;
        else            state <= state_nxt;
    end

    // Expiry beats a same-cycle request; the ack register keeps acks one cycle apart.
    always_comb begin
        state_nxt = state;
        load_disp = 1'b0;
        expire    = (state == SHOW1) && frame_start && !pend_new && (hold == HOLD_W'(1));
        accept    = req.src1_valid && !ack_q && !expire;
        case (state)
            SHOW0: if (accept) state_nxt = PEND1;
            PEND1: begin
                if (frame_start && !accept) begin
                    state_nxt = SHOW1;
                    load_disp = 1'b1;
                end
            end
            SHOW1: begin
                if (expire)                      state_nxt = SHOW0;
                else if (frame_start && pend_new) load_disp = 1'b1;
            end
            default: state_nxt = SHOW0;
        endcase
    end

    always_ff @(posedge clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            latch_buf <= '1;
            disp_buf  <= '1;
            pend_new  <= 1'b0;
            hold      <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) latch_buf <= req.src1_data;
            if (load_disp) begin
                disp_buf <= latch_buf;
                hold     <= HOLD_LOAD;
            end else if ((state == SHOW1) && frame_start) begin
                hold <= hold - HOLD_W'(1);
            end
            // A message accepted while showing waits here until the next frame edge.
            if ((state == SHOW1) && accept) pend_new <= 1'b1;
            else if (load_disp || (state != SHOW1)) pend_new <= 1'b0;
        end
    end

    assign src_byte = digit_byte((state == SHOW1) ? disp_buf : req.src0_data, digit);

    always_ff @(posedge clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            control   <= ANODE_OFF;
            cube_data <= SEG_BLANK;
        end else if (blank) begin
            control   <= ANODE_OFF;
            cube_data <= SEG_BLANK;
        end else begin
            control   <= anode_sel(digit);
            cube_data <= src_byte;
        end
    end

    assign owner        = (state == SHOW1);
    assign busy         = (state != SHOW0);
    assign req.src1_ack = ack_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a 10-cycle slot, 2 blank cycles
// and 3-frame hold, so one frame is 80 clocks.
module tb_seg_display_arbiter;

    localparam logic [63:0] BANNER = 64'h82_99_C0_FF_FF_99_80_C0;
    localparam logic [63:0] MSG_A  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MSG_B  = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] MSG_C  = 64'hA5A5_A5A5_A5A5_A5A5;

    logic       clock;
    logic       sys_rst_n;
    logic [7:0] control;
    logic [7:0] cube_data;
    logic       owner;
    logic       busy;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .SCAN_DIV     (10),
        .BLANK_CYCLES (2),
        .HOLD_FRAMES  (3)
    ) dut (
        .clock     (clock),
        .sys_rst_n (sys_rst_n),
        .req       (bus),
        .control   (control),
        .cube_data (cube_data),
        .owner     (owner),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic [7:0] ctrl;
        logic [7:0] cube;
        logic       own;
    } vec_t;

    vec_t tbl [11];
    int   vectors = 0;
    int   miss    = 0;
    int   n       = 0;   // posedges since last reset release

    task automatic step();
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at n=%0d: got %h want %h", name, n, act, exp);
        end
    endtask

    task automatic chk_disp(input logic [7:0] ctrl, input logic [7:0] cube, input logic own);
        chk("control", control, ctrl);
        chk("cube_data", cube_data, cube);
        chk("owner", owner, own);
    endtask

    task automatic pulse_req(input logic [63:0] data);
        bus.src1_valid = 1'b1;
        bus.src1_data  = data;
        step();
        chk("ack_pulse", bus.src1_ack, 1'b1);
        chk("busy_on", busy, 1'b1);
        bus.src1_valid = 1'b0;
        step();
        chk("ack_drop", bus.src1_ack, 1'b0);
    endtask

    initial begin
        int  run;
        logic hot_ok;

        tbl[0]  = '{1,  8'hFF, 8'hFF, 1'b0};
        tbl[1]  = '{2,  8'hFF, 8'hFF, 1'b0};
        tbl[2]  = '{3,  8'h7F, 8'h82, 1'b0};
        tbl[3]  = '{10, 8'h7F, 8'h82, 1'b0};
        tbl[4]  = '{11, 8'hFF, 8'hFF, 1'b0};
        tbl[5]  = '{13, 8'hBF, 8'h99, 1'b0};
        tbl[6]  = '{33, 8'hEF, 8'hFF, 1'b0};
        tbl[7]  = '{73, 8'hFE, 8'hC0, 1'b0};
        tbl[8]  = '{80, 8'hFE, 8'hC0, 1'b0};
        tbl[9]  = '{81, 8'hFF, 8'hFF, 1'b0};
        tbl[10] = '{83, 8'h7F, 8'h82, 1'b0};

        bus.src0_data  = BANNER;
        bus.src1_valid = 1'b0;
        bus.src1_data  = MSG_A;
        sys_rst_n      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_disp(8'hFF, 8'hFF, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack", bus.src1_ack, 1'b0);
        sys_rst_n = 1'b1;
        n = 0;

        // Idle banner scan
        foreach (tbl[i]) begin
            run_to(tbl[i].n);
            chk_disp(tbl[i].ctrl, tbl[i].cube, tbl[i].own);
        end

        // Single grant, three frames
        run_to(100);
        chk("busy_idle", busy, 1'b0);
        pulse_req(MSG_A);
        run_to(160);
        chk("owner_pend", owner, 1'b0);
        step();
        chk("owner_take", owner, 1'b1);
        run_to(163);
        chk_disp(8'h7F, 8'h00, 1'b1);
        run_to(400);
        chk_disp(8'hFE, 8'h00, 1'b1);
        step();
        chk_disp(8'hFF, 8'hFF, 1'b0);
        chk("busy_release", busy, 1'b0);
        run_to(403);
        chk_disp(8'h7F, 8'h82, 1'b0);

        // Re-request in the second shown frame reloads the hold
        run_to(500);
        pulse_req(MSG_A);
        run_to(561);
        chk("owner_take2", owner, 1'b1);
        run_to(660);
        pulse_req(MSG_B);
        run_to(700);
        chk_disp(8'hFB, 8'h00, 1'b1);
        run_to(723);
        chk_disp(8'h7F, 8'hFE, 1'b1);
        run_to(960);
        chk("owner_hold5", owner, 1'b1);
        step();
        chk("owner_exp5", owner, 1'b0);

        // Request landing on the expiry boundary
        run_to(1000);
        pulse_req(MSG_A);
        run_to(1041);
        chk("owner_take3", owner, 1'b1);
        run_to(1280);
        bus.src1_valid = 1'b1;
        bus.src1_data  = MSG_C;
        step();
        chk("owner_exp_race", owner, 1'b0);
        chk("ack_race_wait", bus.src1_ack, 1'b0);
        chk("busy_race", busy, 1'b0);
        step();
        chk("ack_race", bus.src1_ack, 1'b1);
        bus.src1_valid = 1'b0;
        step();
        chk("ack_race_drop", bus.src1_ack, 1'b0);
        run_to(1360);
        chk("owner_race_pend", owner, 1'b0);
        step();
        chk("owner_race_take", owner, 1'b1);

        // Asynchronous reset in the middle of a shown slot
        run_to(1400);
        chk_disp(8'hEF, 8'hA5, 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_disp(8'hFF, 8'hFF, 1'b0);
        chk("async_busy", busy, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        sys_rst_n = 1'b1;
        n = 0;

        // Ten frames of scan integrity after reset
        run = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            hot_ok = (control == 8'hFF) || $onehot(~control);
            chk("anode_hot", hot_ok, 1'b1);
            chk("post_rst_ack", bus.src1_ack, 1'b0);
            if (k == 3) chk_disp(8'h7F, 8'h82, 1'b0);
            if (control == 8'hFF) begin
                run++;
            end else begin
                if (run != 0) chk("blank_run", run, 2);
                run = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
